// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven initiator for a 16-bit combinational ALU.
// Holds an 8 x 16-bit register file. Accepts one command at a time over a
// valid/ready handshake and returns the written value over a valid/ready
// response channel. A stored carry flag lets multi-word arithmetic chain
// across commands.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready registered)
//   cmd_load              1 = load immediate, 0 = ALU operation
//   cmd_mode, cmd_select  ALU mode / function passed through
//   cmd_use_carry         drive stored carry as ALU carry-in
//   cmd_dst/srca/srcb     register indices
//   cmd_imm               immediate for loads
//   alu_in_a/b, alu_select, alu_mode, alu_carry_in   registered ALU drive
//   alu_result, alu_carry_out                        combinational ALU return
//   rsp_valid/rsp_ready   response handshake (rsp_valid registered)
//   rsp_data, rsp_carry   value written and carry flag after the command
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_load,
  input  logic        cmd_mode,
  input  logic [3:0]  cmd_select,
  input  logic        cmd_use_carry,
  input  logic [2:0]  cmd_dst,
  input  logic [2:0]  cmd_srca,
  input  logic [2:0]  cmd_srcb,
  input  logic [15:0] cmd_imm,
  output logic [15:0] alu_in_a,
  output logic [15:0] alu_in_b,
  output logic [3:0]  alu_select,
  output logic        alu_mode,
  output logic        alu_carry_in,
  input  logic [15:0] alu_result,
  input  logic        alu_carry_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_carry
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e      state_q, state_d;
  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [3:0]  sel_q, sel_d;
  logic        mode_q, mode_d;
  logic        cin_q, cin_d;
  logic [2:0]  dst_q, dst_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rcarry_q, rcarry_d;
  logic        cready_q, cready_d;
  logic        rvalid_q, rvalid_d;
  logic        new_carry;

  always_comb begin
    state_d   = state_q;
    rf_d      = rf_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    mode_d    = mode_q;
    cin_d     = cin_q;
    dst_d     = dst_q;
    rdata_d   = rdata_q;
    rcarry_d  = rcarry_q;
    cready_d  = cready_q;
    rvalid_d  = rvalid_q;
    new_carry = mode_q & alu_carry_out;

    unique case (state_q)
      IDLE: begin
        // cready_q is still 0 on the first cycle out of reset; it rises
        // here, so acceptance always waits for the registered ready.
        cready_d = 1'b1;
        if (cmd_valid && cready_q) begin
          cready_d = 1'b0;
          if (cmd_load) begin
            rf_d[cmd_dst] = cmd_imm;
            rdata_d       = cmd_imm;
            rcarry_d      = carry_q;
            rvalid_d      = 1'b1;
            state_d       = RESP;
          end else begin
            a_d     = rf_q[cmd_srca];
            b_d     = rf_q[cmd_srcb];
            sel_d   = cmd_select;
            mode_d  = cmd_mode;
            cin_d   = cmd_use_carry & carry_q;
            dst_d   = cmd_dst;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        rf_d[dst_q] = alu_result;
        rdata_d     = alu_result;
        carry_d     = new_carry;
        rcarry_d    = new_carry;
        rvalid_d    = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rvalid_d = 1'b0;
          cready_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rf_q     <= '{default: '0};
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      mode_q   <= 1'b0;
      cin_q    <= 1'b0;
      dst_q    <= '0;
      rdata_q  <= '0;
      rcarry_q <= 1'b0;
      cready_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rf_q     <= rf_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      mode_q   <= mode_d;
      cin_q    <= cin_d;
      dst_q    <= dst_d;
      rdata_q  <= rdata_d;
      rcarry_q <= rcarry_d;
      cready_q <= cready_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign cmd_ready    = cready_q;
  assign rsp_valid    = rvalid_q;
  assign rsp_data     = rdata_q;
  assign rsp_carry    = rcarry_q;
  assign alu_in_a     = a_q;
  assign alu_in_b     = b_q;
  assign alu_select   = sel_q;
  assign alu_mode     = mode_q;
  assign alu_carry_in = cin_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_load = 1'b0;
  logic        cmd_mode = 1'b0;
  logic [3:0]  cmd_select = '0;
  logic        cmd_use_carry = 1'b0;
  logic [2:0]  cmd_dst = '0, cmd_srca = '0, cmd_srcb = '0;
  logic [15:0] cmd_imm = '0;
  logic [15:0] alu_in_a, alu_in_b;
  logic [3:0]  alu_select;
  logic        alu_mode, alu_carry_in;
  logic [15:0] alu_result;
  logic        alu_carry_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_carry;

  logic rdy_mode = 1'b0;   // 0 = forced value, 1 = random
  logic rdy_force = 1'b1;
  logic rdy_rand = 1'b1;
  assign rsp_ready = rdy_mode ? rdy_rand : rdy_force;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0, acc_prev = 0;
  logic [16:0] exp_q[$];
  logic [16:0] last_rsp = '0;
  logic [15:0] rf_m [8];
  logic        carry_m = 1'b0;

  // 74181-style function table, active-high data.
  function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] s, input logic m, input logic c);
    logic [15:0] lo;
    logic [16:0] ea, eb, ec;
    ea = {1'b0, a};
    eb = {1'b0, b};
    ec = {16'd0, c};
    if (!m) begin
      case (s)
        4'd0:  lo = ~a;
        4'd1:  lo = ~(a | b);
        4'd2:  lo = ~a & b;
        4'd3:  lo = '0;
        4'd4:  lo = ~(a & b);
        4'd5:  lo = ~b;
        4'd6:  lo = a ^ b;
        4'd7:  lo = a & ~b;
        4'd8:  lo = ~a | b;
        4'd9:  lo = ~(a ^ b);
        4'd10: lo = b;
        4'd11: lo = a & b;
        4'd12: lo = '1;
        4'd13: lo = a | ~b;
        4'd14: lo = a | b;
        default: lo = a;
      endcase
      return {1'b0, lo};
    end
    case (s)
      4'd0:  return ea + ec;
      4'd6:  return ea + {1'b0, ~b} + ec;
      4'd12: return ea + ea + ec;
      4'd15: return ea + 17'h0FFFF + ec;
      default: return ea + eb + ec;
    endcase
  endfunction

  assign {alu_carry_out, alu_result} = alu_f(alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in);

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_mode(cmd_mode), .cmd_select(cmd_select),
    .cmd_use_carry(cmd_use_carry), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca),
    .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select),
    .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always begin
    @(posedge clk);
    #1 rdy_rand = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: compare every response handshake against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got carry=%0b data=%h, required no response", rsp_carry, rsp_data);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({rsp_carry, rsp_data} !== e) begin
          n_fail++;
          $display("FAIL rsp: got carry=%0b data=%h, required carry=%0b data=%h",
                   rsp_carry, rsp_data, e[16], e[15:0]);
        end
      end
      last_rsp = {rsp_carry, rsp_data};
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    carry_m = 1'b0;
  endtask

  task automatic send(input logic ld, input logic m, input logic [3:0] s, input logic uc,
                      input logic [2:0] d, input logic [2:0] sa, input logic [2:0] sb,
                      input logic [15:0] imm);
    bit ok;
    logic [15:0] ea, eb;
    logic        ec;
    logic [16:0] r;
    cmd_load = ld; cmd_mode = m; cmd_select = s; cmd_use_carry = uc;
    cmd_dst = d; cmd_srca = sa; cmd_srcb = sb; cmd_imm = imm;
    cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: got cmd_ready=0 for 200 cycles, required 1");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_prev = acc_cyc;
    acc_cyc = cyc;
    if (ld) begin
      rf_m[d] = imm;
      exp_q.push_back({carry_m, imm});
    end else begin
      ea = rf_m[sa];
      eb = rf_m[sb];
      ec = uc & carry_m;
      r = alu_f(ea, eb, s, m, ec);
      rf_m[d] = r[15:0];
      carry_m = m & r[16];
      exp_q.push_back({carry_m, r[15:0]});
      check("alu_drive", 64'({alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in, rsp_valid}),
            64'({ea, eb, s, m, ec, 1'b0}));
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    logic [15:0] held;
    model_reset();
    // Reset behaviour.
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({cmd_ready, rsp_valid, rsp_data, rsp_carry, alu_in_a,
                                alu_in_b, alu_select, alu_mode, alu_carry_in}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 check("ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1 check("ready_after_edge", 64'(cmd_ready), 64'd1);
    send(1, 0, 4'd0, 0, 3'd0, 3'd0, 3'd0, 16'h0000);
    send(0, 1, 4'd0, 0, 3'd2, 3'd7, 3'd0, 16'h0);
    drain();
    check("reset_r7_pass", 64'(last_rsp), 64'h0);

    // Logic operation.
    send(1, 0, 4'd0, 0, 3'd1, 3'd0, 3'd0, 16'h1234);
    send(1, 0, 4'd0, 0, 3'd2, 3'd0, 3'd0, 16'h00FF);
    send(0, 0, 4'd6, 0, 3'd3, 3'd1, 3'd2, 16'h0);
    drain();
    check("logic_xor", 64'(last_rsp), 64'h0_12CB);

    // Carry chain.
    send(1, 0, 4'd0, 0, 3'd1, 3'd0, 3'd0, 16'hFFFF);
    send(1, 0, 4'd0, 0, 3'd2, 3'd0, 3'd0, 16'h0001);
    send(1, 0, 4'd0, 0, 3'd4, 3'd0, 3'd0, 16'h0000);
    send(1, 0, 4'd0, 0, 3'd5, 3'd0, 3'd0, 16'h0000);
    send(0, 1, 4'd9, 0, 3'd6, 3'd1, 3'd2, 16'h0);
    drain();
    check("chain_low", 64'(last_rsp), 64'h1_0000);
    send(0, 1, 4'd9, 1, 3'd7, 3'd4, 3'd5, 16'h0);
    drain();
    check("chain_high", 64'(last_rsp), 64'h0_0001);

    // Backpressure with a second command waiting.
    @(posedge clk); #1 rdy_force = 1'b0;
    send(0, 1, 4'd9, 0, 3'd3, 3'd1, 3'd1, 16'h0);
    held = rf_m[3];
    cmd_load = 1'b1; cmd_dst = 3'd6; cmd_imm = 16'hBEEF; cmd_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("backpressure_hold", 64'({rsp_valid, cmd_ready, rsp_data}), 64'({1'b1, 1'b0, held}));
    end
    @(posedge clk); #1 rdy_force = 1'b1;
    begin
      int hs;
      hs = cyc + 1;
      send(1, 0, 4'd0, 0, 3'd6, 3'd0, 3'd0, 16'hBEEF);
      check("accept_after_release", 64'(acc_cyc - hs), 64'd1);
    end
    drain();

    // Throughput.
    send(0, 1, 4'd9, 0, 3'd1, 3'd2, 3'd3, 16'h0);
    send(0, 0, 4'd14, 0, 3'd2, 3'd3, 3'd4, 16'h0);
    check("alu_spacing_1", 64'(acc_cyc - acc_prev), 64'd3);
    send(0, 1, 4'd6, 1, 3'd5, 3'd1, 3'd2, 16'h0);
    check("alu_spacing_2", 64'(acc_cyc - acc_prev), 64'd3);
    send(1, 0, 4'd0, 0, 3'd0, 3'd0, 3'd0, 16'hA5A5);
    send(1, 0, 4'd0, 0, 3'd1, 3'd0, 3'd0, 16'h5A5A);
    check("load_spacing", 64'(acc_cyc - acc_prev), 64'd2);
    drain();

    // Reset during ISSUE.
    send(1, 0, 4'd0, 0, 3'd1, 3'd0, 3'd0, 16'hFFFF);
    send(0, 1, 4'd9, 0, 3'd3, 3'd1, 3'd1, 16'h0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check("reset_midop_quiet", 64'({rsp_valid, cmd_ready}), 64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    send(0, 0, 4'd15, 0, 3'd6, 3'd3, 3'd0, 16'h0);
    drain();
    check("r3_cleared", 64'(last_rsp), 64'h0);
    send(1, 0, 4'd0, 0, 3'd0, 3'd0, 3'd0, 16'h0055);
    drain();
    check("carry_cleared", 64'(last_rsp), 64'h0_0055);

    // Randomized traffic with random response backpressure.
    rdy_mode = 1'b1;
    for (int n = 0; n < 80; n++) begin
      send(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 16'($urandom));
    end
    drain();
    rdy_mode = 1'b0;
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven initiator for the 16-bit combinational ALU. It holds an 8-entry × 16-bit register file and accepts one command at a time over a valid/ready handshake. For each ALU command it drives registered operands and control into the ALU, captures the result and carry one cycle later, writes the result back, and returns it over a valid/ready response channel. A stored carry flag allows multi-word arithmetic to be chained across commands.

## Interface
Parameters:
- None. Data width is fixed at 16 and the register file at 8 entries.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_load  in  1  1 = load immediate; 0 = ALU operation
- cmd_mode  in  1  ALU mode passed through (0 = logic, 1 = arithmetic)
- cmd_select  in  4  ALU function select passed through
- cmd_use_carry  in  1  1 = drive the stored carry flag as carry_in; 0 = drive 0
- cmd_dst, cmd_srca, cmd_srcb  in  3 each  destination and source register indices
- cmd_imm  in  16  immediate value for loads
- alu_in_a, alu_in_b  out  16 each  operands to the ALU
- alu_select  out  4, alu_mode  out  1, alu_carry_in  out  1  control to the ALU
- alu_result  in  16, alu_carry_out  in  1  combinational ALU outputs
- rsp_valid  out  1, rsp_ready  in  1  response handshake
- rsp_data  out  16  value written to the destination register
- rsp_carry  out  1  carry flag after the command

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch the command.
- ALU command accepted:
  - On the accept edge, register alu_in_a = rf[srca] and alu_in_b = rf[srcb].
  - On the same edge, register alu_select = cmd_select, alu_mode = cmd_mode, alu_carry_in = cmd_use_carry & carry_q.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ALU outputs settle.
  - On the next edge: rf[dst] ← alu_result; rsp_data ← alu_result.
  - carry_q ← alu_carry_out if alu_mode = 1; carry_q ← 0 if alu_mode = 0.
  - rsp_carry ← new carry_q. Go to RESP.
- Load command accepted:
  - On the accept edge: rf[dst] ← cmd_imm; rsp_data ← cmd_imm; rsp_carry ← carry_q (carry unchanged).
  - Go directly to RESP. ALU outputs are not updated.
- RESP:
  - rsp_valid = 1. rsp_data and rsp_carry are held stable until rsp_ready.
  - On the rsp_valid & rsp_ready edge, go to IDLE.
- ALU drive outputs hold their last values outside ISSUE.
- Register reads use register-file contents as of the accept edge. Any destination, including one equal to a source, is legal; the write takes effect after the read.
- Carry chaining: carry_q persists across commands until the next ALU command overwrites it. Loads never modify it.
- Reset (asynchronous, any state, including mid-ISSUE or mid-RESP):
  - State → IDLE; rf[0..7] = 0; carry_q = 0.
  - All outputs 0, including cmd_ready and rsp_valid.
  - An in-flight command is dropped: no write-back, no response.
  - cmd_ready rises at the first clk edge after rst_n deasserts.

## Timing
- cmd_ready and rsp_valid are registered and mutually exclusive.
- cmd_ready drops on the accept edge and rises on the response handshake edge.
- ALU command: accept at edge E0; ALU driven during E0→E1; rsp_valid high after E1. With rsp_ready = 1, the handshake is at E2 and the next accept is possible at E3, giving 3 cycles per operation.
- Load command: accept at E0, rsp_valid high after E0, handshake at E1, next accept at E2.
- cmd_valid while cmd_ready = 0 is ignored; the command inputs are not sampled.
- Back-to-back dependent commands see the prior result, because write-back precedes the next accept.

## Test plan
- Reset: hold rst_n low with clk running → all outputs 0; release → cmd_ready = 1 after the first edge; a load of r0 followed by an op with mode = 1, select = 0000, srca = r7 returns 0x0000.
- Logic operation: load r1 = 0x1234, load r2 = 0x00FF; issue mode = 0, select = 0110, dst = r3 → during ISSUE alu_in_a = 0x1234, alu_in_b = 0x00FF, alu_select = 0110, alu_mode = 0; response rsp_data = 0x12CB, rsp_carry = 0.
- Carry chain: load r1 = 0xFFFF, r2 = 0x0001, r4 = 0, r5 = 0; add (mode = 1, select = 1001, use_carry = 0) r1 + r2 → rsp_data = 0x0000, rsp_carry = 1; then add r4 + r5 with use_carry = 1 → alu_carry_in = 1, rsp_data = 0x0001.
- Backpressure: hold rsp_ready = 0 for 5 cycles with cmd_valid = 1 → rsp_valid stays 1, rsp_data stable, cmd_ready = 0, no second command accepted; raise rsp_ready → next command accepted one cycle later.
- Reset mid-operation: assert rst_n low during ISSUE of an add to r3 → no rsp_valid; after release, reading r3 returns 0x0000 and carry_q = 0.
- Throughput: three independent ALU commands with rsp_ready = 1 and cmd_valid held high → accepts exactly 3 cycles apart; a load followed by a load → accepts 2 cycles apart.
